// File: rtl/sram_uart_fifo.sv
// sram_uart_fifo: 16550-subset register window on a 64-bit SRAM port, TX/RX FIFOs.
// Define UART_FIFO_IRQ_EN for a writable IER, computed IIR and the level irq.
module sram_uart_fifo #(
    parameter logic [63:0] BASE_ADDR = 64'h6000_0000,
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 256
) (
    input  logic        clka,
    input  logic        rstn,
    input  logic [63:0] addra,
    input  logic [63:0] dina,
    input  logic [7:0]  wea,
    input  logic        ena,
    output logic [63:0] douta,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        irq
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_CAP = TX_DEPTH[TAW:0];
    localparam logic [RAW:0] RX_CAP = RX_DEPTH[RAW:0];

    if ((TX_DEPTH < 2) || ((TX_DEPTH & (TX_DEPTH - 1)) != 0)) begin : g_bad_tx
        $error("TX_DEPTH must be a power of two >= 2");
    end
    if ((RX_DEPTH < 2) || ((RX_DEPTH & (RX_DEPTH - 1)) != 0)) begin : g_bad_rx
        $error("RX_DEPTH must be a power of two >= 2");
    end

    logic [7:0]     tx_mem_q [TX_DEPTH];
    logic [TAW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [TAW:0]   tx_cnt_q, tx_cnt_d;
    logic [7:0]     rx_mem_q [RX_DEPTH];
    logic [RAW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [RAW:0]   rx_cnt_q, rx_cnt_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_valid_q, tx_valid_d;
    logic           oe_q, oe_d;
    logic [63:0]    douta_q, douta_d;

    logic       rd, tx_empty, tx_full, rx_empty, rx_full;
    logic       tx_push, tx_pop, rx_push, rx_pop, oe_set;
    logic       thre, temt, dr;
    logic [2:0] sel;
    logic [1:0] ier_v;
    logic       irq_rx, irq_th, unused_ier;
    logic [7:0] iir, lsr, rbr;
    logic [63:0] rd_word;

    assign sel      = addra[2:0];
    assign rd       = ena & (wea == 8'h00);
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == TX_CAP);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RX_CAP);

    assign tx_push = ena & wea[0] & ~tx_full;
    assign tx_pop  = (~tx_valid_q | tx_ready) & ~tx_empty;
    assign rx_pop  = rd & (sel == 3'd0) & ~rx_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign rx_push = rx_ready & (~rx_full | rx_pop);
    assign oe_set  = rx_ready & rx_full & ~rx_pop;

    assign thre = tx_empty;
    assign temt = tx_empty & ~tx_valid_q;
    assign dr   = ~rx_empty;

`ifdef UART_FIFO_IRQ_EN
    logic [1:0] ier_q;
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            ier_q <= 2'b00;
        end else if (ena & wea[1]) begin
            ier_q <= dina[9:8];
        end
    end
    assign ier_v      = ier_q;
    assign irq_rx     = ier_q[0] & dr;
    assign irq_th     = ier_q[1] & thre;
    assign unused_ier = 1'b0;
`else
    assign ier_v      = 2'b00;
    assign irq_rx     = 1'b0;
    assign irq_th     = 1'b0;
    assign unused_ier = ^dina[9:8];
`endif

    assign iir = irq_rx ? 8'hC4 : (irq_th ? 8'hC2 : 8'hC1);
    assign irq = irq_rx | irq_th;
    assign lsr = {1'b0, temt, thre, 3'b000, oe_q, dr};
    assign rbr = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
    assign rd_word = {8'h00, 8'h00, lsr, 8'h00, 8'h03, iir, {6'b0, ier_v}, rbr};

    always_comb begin
        tx_wp_d    = tx_wp_q;
        tx_rp_d    = tx_rp_q;
        tx_cnt_d   = tx_cnt_q + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
        rx_wp_d    = rx_wp_q;
        rx_rp_d    = rx_rp_q;
        rx_cnt_d   = rx_cnt_q + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        oe_d       = oe_q;
        douta_d    = rd ? rd_word : douta_q;
        if (tx_push) tx_wp_d = tx_wp_q + TAW'(1);
        if (tx_pop)  tx_rp_d = tx_rp_q + TAW'(1);
        if (rx_push) rx_wp_d = rx_wp_q + RAW'(1);
        if (rx_pop)  rx_rp_d = rx_rp_q + RAW'(1);
        if (tx_pop) begin
            tx_data_d  = tx_mem_q[tx_rp_q];
            tx_valid_d = 1'b1;
        end else if (tx_valid_q & tx_ready) begin
            tx_valid_d = 1'b0;
        end
        // A fresh overrun outranks the clear-on-read of the same cycle.
        if (oe_set) begin
            oe_d = 1'b1;
        end else if (rd & (sel == 3'd5)) begin
            oe_d = 1'b0;
        end
    end

    always_ff @(posedge clka) begin
        if (tx_push) tx_mem_q[tx_wp_q] <= dina[7:0];
        if (rx_push) rx_mem_q[rx_wp_q] <= rx_data;
    end

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_cnt_q   <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_cnt_q   <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            oe_q       <= 1'b0;
            douta_q    <= 64'h0;
        end else begin
            tx_wp_q    <= tx_wp_d;
            tx_rp_q    <= tx_rp_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_wp_q    <= rx_wp_d;
            rx_rp_q    <= rx_rp_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            oe_q       <= oe_d;
            douta_q    <= douta_d;
        end
    end

    assign douta    = douta_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;

    logic unused_ok;
    assign unused_ok = ^{addra[63:3], dina[63:10], BASE_ADDR, unused_ier};
endmodule

// File: tb/tb_sram_uart_fifo.sv
// Bench for sram_uart_fifo: queue-based reference model plus directed literals.
// Builds with or without UART_FIFO_IRQ_EN.
module tb_sram_uart_fifo;
    localparam int TXD = 16;
    localparam int RXD = 256;
    localparam logic [63:0] BASE = 64'h6000_0000;
`ifdef UART_FIFO_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        clka = 1'b0;
    logic        rstn = 1'b0;
    logic [63:0] addra = BASE;
    logic [63:0] dina = 64'h0;
    logic [7:0]  wea = 8'h00;
    logic        ena = 1'b0;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready = 1'b0;
    wire  [63:0] douta;
    wire  [7:0]  tx_data;
    wire         tx_valid;
    wire         irq;

    always #5 clka = ~clka;

    sram_uart_fifo #(.BASE_ADDR(BASE), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clka(clka), .rstn(rstn), .addra(addra), .dina(dina), .wea(wea),
        .ena(ena), .douta(douta), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_ready(rx_ready), .irq(irq)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  m_txq[$];
    logic [7:0]  m_rxq[$];
    logic [7:0]  m_log[$];
    logic [7:0]  d_log[$];
    bit          m_sv = 1'b0;
    logic [7:0]  m_sd = 8'h00;
    bit          m_oe = 1'b0;
    logic [1:0]  m_ier = 2'b00;
    logic [63:0] m_do = 64'h0;
    logic [7:0]  rxv[RXD+1];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] m_lsr();
        bit thre;
        thre = (m_txq.size() == 0);
        return {1'b0, thre && !m_sv, thre, 3'b000, m_oe, m_rxq.size() != 0};
    endfunction

    function automatic bit m_irq_rx();
        return IRQ && m_ier[0] && (m_rxq.size() != 0);
    endfunction

    function automatic bit m_irq_th();
        return IRQ && m_ier[1] && (m_txq.size() == 0);
    endfunction

    task automatic model_reset();
        m_txq.delete();
        m_rxq.delete();
        m_sv = 1'b0;
        m_oe = 1'b0;
        m_ier = 2'b00;
        m_do = 64'h0;
    endtask

    task automatic model_step();
        bit rd, hs, take, full, pop;
        int pre;
        logic [7:0] rbr, iir;
        rd = ena && (wea == 8'h00);
        if (rd) begin
            rbr = (m_rxq.size() != 0) ? m_rxq[0] : 8'h00;
            iir = m_irq_rx() ? 8'hC4 : (m_irq_th() ? 8'hC2 : 8'hC1);
            m_do = {16'h0, m_lsr(), 8'h00, 8'h03, iir, 6'b0, m_ier, rbr};
        end
        hs = m_sv && tx_ready;
        take = (!m_sv || tx_ready) && (m_txq.size() != 0);
        pre = m_txq.size();
        if (hs) m_log.push_back(m_sd);
        if (take) begin
            m_sd = m_txq.pop_front();
            m_sv = 1'b1;
        end else if (hs) begin
            m_sv = 1'b0;
        end
        if (ena && wea[0] && pre < TXD) m_txq.push_back(dina[7:0]);
        full = (m_rxq.size() == RXD);
        pop = rd && (addra[2:0] == 3'd0) && (m_rxq.size() != 0);
        if (pop) void'(m_rxq.pop_front());
        if (rd && addra[2:0] == 3'd5) m_oe = 1'b0;
        if (rx_ready) begin
            if (!full || pop) m_rxq.push_back(rx_data);
            else m_oe = 1'b1;
        end
        if (IRQ && ena && wea[1]) m_ier = dina[9:8];
    endtask

    task automatic tick();
        @(posedge clka);
        if (rstn) model_step();
        @(negedge clka);
    endtask

    task automatic wr(input logic [7:0] b);
        ena = 1'b1; wea = 8'h01; addra = BASE; dina = {56'h0, b};
        tick();
        ena = 1'b0; wea = 8'h00;
    endtask

    task automatic wr_ier(input logic [1:0] v);
        ena = 1'b1; wea = 8'h02; addra = BASE + 64'd1; dina = {54'h0, v, 8'h00};
        tick();
        ena = 1'b0; wea = 8'h00;
    endtask

    task automatic rd(input logic [2:0] a, output logic [63:0] v);
        ena = 1'b1; wea = 8'h00; addra = BASE + {61'h0, a};
        tick();
        ena = 1'b0;
        v = douta;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_ready = 1'b1; rx_data = b;
        tick();
        rx_ready = 1'b0;
    endtask

    task automatic drain(input string nm);
        int i;
        i = 0;
        tx_ready = 1'b1;
        while ((tx_valid || m_txq.size() != 0) && i < 200) begin
            tick();
            i++;
        end
        chk(nm, 64'(tx_valid), 64'd0);
    endtask

    // Per-cycle comparison against the model, plus DUT-side PHY capture.
    initial begin
        bit pv;
        logic [7:0] pd;
        pv = 1'b0;
        pd = 8'h00;
        forever begin
            @(posedge clka);
            #1;
            if (!rstn) begin
                pv = 1'b0;
            end else begin
                if (pv && tx_ready) d_log.push_back(pd);
                if (pv && !tx_ready) chk("tx_hold", 64'(tx_data), 64'(pd));
                pv = tx_valid;
                pd = tx_data;
            end
            chk("tx_valid", 64'(tx_valid), 64'(m_sv));
            if (m_sv) chk("tx_data", 64'(tx_data), 64'(m_sd));
            chk("irq", 64'(irq), 64'(m_irq_rx() || m_irq_th()));
            chk("douta", douta, m_do);
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] v;
        logic [7:0] nb;
        repeat (3) @(negedge clka);
        #2 rstn = 1'b1;
        chk("rst_douta", douta, 64'h0);
        chk("rst_txv", 64'(tx_valid), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        rd(3'd5, v);
        chk("rst_lsr", 64'(v[47:40]), 64'h60);

        // Reset in the middle of traffic
        tx_ready = 1'b0;
        wr(8'hA1); wr(8'hA2); wr(8'hA3);
        rx_push(8'h55); rx_push(8'h66);
        #2 rstn = 1'b0;
        model_reset();
        tick(); tick();
        #2 rstn = 1'b1;
        chk("mid_rst_txv", 64'(tx_valid), 64'd0);
        chk("mid_rst_douta", douta, 64'h0);
        rd(3'd5, v);
        chk("mid_rst_lsr", 64'(v[47:40]), 64'h60);
        rd(3'd0, v);
        chk("mid_rst_rbr", 64'(v[7:0]), 64'h0);

        // Three bytes with a stalled PHY
        m_log.delete(); d_log.delete();
        tx_ready = 1'b0;
        wr(8'h41); wr(8'h42); wr(8'h43);
        tick(); tick(); tick();
        drain("t2_drain");
        chk("t2_cnt", 64'(d_log.size()), 64'd3);
        chk("t2_b0", 64'(d_log[0]), 64'h41);
        chk("t2_b1", 64'(d_log[1]), 64'h42);
        chk("t2_b2", 64'(d_log[2]), 64'h43);
        chk("t2_model_b0", 64'(m_log[0]), 64'h41);
        rd(3'd5, v);
        chk("t2_lsr", 64'(v[47:40]), 64'h60);

        // Overfill the TX side
        m_log.delete(); d_log.delete();
        tx_ready = 1'b0;
        for (int i = 0; i < TXD + 2; i++) wr(8'(8'h10 + i));
        tick(); tick();
        rd(3'd5, v);
        chk("t3_lsr_full", 64'(v[47:40]), 64'h00);
        drain("t3_drain");
        chk("t3_cnt", 64'(d_log.size()), 64'(TXD + 1));
        for (int i = 0; i < d_log.size(); i++)
            chk("t3_byte", 64'(d_log[i]), 64'(8'(8'h10 + i)));

        // RX overrun
        for (int i = 0; i <= RXD; i++) rxv[i] = 8'($urandom);
        for (int i = 0; i <= RXD; i++) rx_push(rxv[i]);
        rd(3'd5, v);
        chk("t4_oe_dr", 64'(v[41:40]), 64'h3);
        chk("t4_lsr", 64'(v[47:40]), 64'h63);
        for (int i = 0; i < RXD; i++) begin
            rd(3'd0, v);
            chk("t4_rbr", 64'(v[7:0]), 64'(rxv[i]));
        end
        rd(3'd5, v);
        chk("t4_oe_clr", 64'(v[41]), 64'd0);
        chk("t4_lsr2", 64'(v[47:40]), 64'h60);

        // Push and pop together while full
        for (int i = 0; i < RXD; i++) rxv[i] = 8'($urandom);
        for (int i = 0; i < RXD; i++) rx_push(rxv[i]);
        nb = 8'($urandom);
        ena = 1'b1; wea = 8'h00; addra = BASE; rx_ready = 1'b1; rx_data = nb;
        tick();
        ena = 1'b0; rx_ready = 1'b0;
        chk("t5_first", 64'(douta[7:0]), 64'(rxv[0]));
        rd(3'd5, v);
        chk("t5_no_oe", 64'(v[47:40]), 64'h61);
        for (int i = 1; i < RXD; i++) begin
            rd(3'd0, v);
            chk("t5_rbr", 64'(v[7:0]), 64'(rxv[i]));
        end
        rd(3'd0, v);
        chk("t5_last", 64'(v[7:0]), 64'(nb));
        rd(3'd5, v);
        chk("t5_lsr", 64'(v[47:40]), 64'h60);

`ifdef UART_FIFO_IRQ_EN
        wr_ier(2'b01);
        chk("irq_off", 64'(irq), 64'd0);
        rx_push(8'h5A);
        chk("irq_rx_on", 64'(irq), 64'd1);
        rd(3'd2, v);
        chk("iir_rx", 64'(v[23:16]), 64'hC4);
        rd(3'd0, v);
        chk("irq_rx_off", 64'(irq), 64'd0);
        rd(3'd2, v);
        chk("iir_none", 64'(v[23:16]), 64'hC1);
        wr_ier(2'b10);
        chk("irq_th_on", 64'(irq), 64'd1);
        rd(3'd2, v);
        chk("iir_th", 64'(v[23:16]), 64'hC2);
        chk("ier_rd", 64'(v[15:8]), 64'h02);
        wr_ier(2'b00);
`else
        wr_ier(2'b11);
        rd(3'd2, v);
        chk("iir_const", 64'(v[23:16]), 64'hC1);
        chk("ier_zero", 64'(v[15:8]), 64'h00);
        chk("irq_tied", 64'(irq), 64'd0);
`endif

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            ena = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) wea = 8'h00;
            else wea = 8'($urandom);
            addra = BASE + 64'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) addra = BASE;
            dina = {$urandom, $urandom};
            rx_ready = ($urandom_range(0, 3) == 0);
            rx_data = 8'($urandom);
            tx_ready = ($urandom_range(0, 1) == 0);
            tick();
        end
        ena = 1'b0; wea = 8'h00; rx_ready = 1'b0;
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
